// File: rtl/riscv_pkg.sv
// Shared constants for the single-cycle RV64 datapath: opcode/funct
// encodings, ALU operations, reset-initial state and the instruction ROM image.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } aluOp_e;

    // addi x0,x0,0 fills every ROM word outside the program image
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    localparam logic [63:0] RESET_PC       = 64'd0;
    localparam int          RESET_DMEM_IDX = 23;
    localparam logic [63:0] RESET_DMEM_VAL = 64'd3;

    // Power-on contents of the register file: x6 = 2, x7 = 3, rest zero
    function automatic logic [63:0] resetRegValue(input int idx);
        case (idx)
            6:       return 64'd2;
            7:       return 64'd3;
            default: return 64'd0;
        endcase
    endfunction

    // Program image of the instruction ROM, indexed by word
    function automatic logic [31:0] romWord(input logic [63:0] idx);
        case (idx)
            64'd0:   return 32'h00E08793;
            64'd1:   return 32'h007302B3;
            64'd2:   return 32'h005782B3;
            64'd3:   return 32'h406787B3;
            64'd4:   return 32'h0042A783;
            64'd5:   return 32'h00F00033;
            64'd6:   return 32'h0057A023;
            64'd7:   return 32'h0007A283;
            64'd8:   return 32'h005782B3;
            64'd9:   return 32'h00F28463;
            64'd10:  return 32'h005782B3;
            default: return NOP_WORD;
        endcase
    endfunction

endpackage

// File: rtl/datapath_alu64.sv
// 64-bit adder/subtractor with a zero flag; wraps modulo 2^64.
module alu64
    import riscv_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  aluOp_e      op_i,
    output logic [63:0] result_o,
    output logic        zero_o
);

    // Add or subtract, then flag an all-zero result for beq
    always_comb begin
        result_o = (op_i == ALU_SUB) ? (a_i - b_i) : (a_i + b_i);
        zero_o   = (result_o == 64'd0);
    end

endmodule

// File: rtl/datapath.sv
// Single-cycle RV64 datapath: ROM fetch, inline decode, register file,
// data memory and PC logic around one shared alu64.
module datapath
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] NewPC,
    input  logic        Jump,
    input  logic        PCWrite,
    output logic [31:0] Instruction,
    output logic        zero,
    output logic [63:0] PCNow,
    output logic [63:0] PCNext4,
    output logic [63:0] writedataa,
    output logic [63:0] readdata1,
    output logic [63:0] readdata2
);

    localparam int DIDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [63:0]       pcQ, pcD;
    logic [63:0]       regsQ [32];
    logic [63:0]       dmemQ [DMEM_WORDS];

    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [4:0]        rs1, rs2, rd;
    logic [63:0]       immI, immS, immB, imm;
    logic              regWrite, memWrite, isLoad, isBranch, useImm;
    aluOp_e            aluOp;
    logic [63:0]       aluB, aluResult, loadData;
    logic [DIDX_W-1:0] dmemIdx;
    logic              regWe, memWe;

    assign PCNow       = pcQ;
    assign PCNext4     = pcQ + 64'd4;
    assign Instruction = romWord((pcQ >> 2) % 64'(IMEM_WORDS));

    assign opcode = Instruction[6:0];
    assign rd     = Instruction[11:7];
    assign funct3 = Instruction[14:12];
    assign rs1    = Instruction[19:15];
    assign rs2    = Instruction[24:20];
    assign funct7 = Instruction[31:25];

    assign immI = {{52{Instruction[31]}}, Instruction[31:20]};
    assign immS = {{52{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
    assign immB = {{51{Instruction[31]}}, Instruction[31], Instruction[7],
                   Instruction[30:25], Instruction[11:8], 1'b0};

    // Decode the opcode into control signals; anything unrecognised is a NOP
    always_comb begin
        regWrite = 1'b0;
        memWrite = 1'b0;
        isLoad   = 1'b0;
        isBranch = 1'b0;
        useImm   = 1'b0;
        imm      = immI;
        aluOp    = ALU_ADD;
        case (opcode)
            OPC_RTYPE: begin
                if (funct3 == F3_ADDSUB && funct7 == F7_ADD) begin
                    regWrite = 1'b1;
                end else if (funct3 == F3_ADDSUB && funct7 == F7_SUB) begin
                    regWrite = 1'b1;
                    aluOp    = ALU_SUB;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == F3_ADDI) begin
                    regWrite = 1'b1;
                    useImm   = 1'b1;
                end
            end
            OPC_LOAD: begin
                regWrite = 1'b1;
                isLoad   = 1'b1;
                useImm   = 1'b1;
            end
            OPC_STORE: begin
                memWrite = 1'b1;
                useImm   = 1'b1;
                imm      = immS;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    isBranch = 1'b1;
                    aluOp    = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    assign readdata1 = (rs1 == 5'd0) ? 64'd0 : regsQ[rs1];
    assign readdata2 = (rs2 == 5'd0) ? 64'd0 : regsQ[rs2];
    assign aluB      = useImm ? imm : readdata2;

    alu64 uAlu (
        .a_i      (readdata1),
        .b_i      (aluB),
        .op_i     (aluOp),
        .result_o (aluResult),
        .zero_o   (zero)
    );

    assign dmemIdx    = DIDX_W'(aluResult % 64'(DMEM_WORDS));
    assign loadData   = dmemQ[dmemIdx];
    assign writedataa = isLoad ? loadData : aluResult;

    // Architectural writes only commit on edges where the instruction retires
    assign regWe = regWrite && PCWrite && (rd != 5'd0);
    assign memWe = memWrite && PCWrite;

    // Select the next PC: hold, jump, taken beq, or sequential
    always_comb begin
        pcD = pcQ;
        if (PCWrite) begin
            if (Jump) begin
                pcD = NewPC;
            end else if (isBranch && zero) begin
                pcD = pcQ + immB;
            end else begin
                pcD = PCNext4;
            end
        end
    end

    // PC register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pcQ <= RESET_PC;
        end else begin
            pcQ <= pcD;
        end
    end

    // Register file; x0 is never written so it stays at its zero reset value
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regsQ[i] <= resetRegValue(i);
            end
        end else if (regWe) begin
            regsQ[rd] <= writedataa;
        end
    end

    // Data memory: whole 64-bit words, written with rs2 on stores
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmemQ[i] <= (i == RESET_DMEM_IDX) ? RESET_DMEM_VAL : 64'd0;
            end
        end else if (memWe) begin
            dmemQ[dmemIdx] <= readdata2;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the single-cycle RV64 datapath. Expected
// write-back values are queued as each step is driven and popped when the
// combinational result is sampled, half a period away from the rising edge.
module tb_datapath;

    logic        Clk;
    logic        Reset;
    logic [63:0] NewPC;
    logic        Jump;
    logic        PCWrite;
    logic [31:0] Instruction;
    logic        zero;
    logic [63:0] PCNow;
    logic [63:0] PCNext4;
    logic [63:0] writedataa;
    logic [63:0] readdata1;
    logic [63:0] readdata2;

    int checks   = 0;
    int failures = 0;

    logic [63:0] expQ [$];
    logic [63:0] wdSeq [11] = '{64'd14, 64'd5, 64'd19, 64'd12, 64'd3, 64'd3,
                                64'd3, 64'd19, 64'd22, 64'd19, 64'd25};

    datapath #(.IMEM_WORDS(64), .DMEM_WORDS(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .NewPC       (NewPC),
        .Jump        (Jump),
        .PCWrite     (PCWrite),
        .Instruction (Instruction),
        .zero        (zero),
        .PCNow       (PCNow),
        .PCNext4     (PCNext4),
        .writedataa  (writedataa),
        .readdata1   (readdata1),
        .readdata2   (readdata2)
    );

    // Free-running 10-unit clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one step's controls and queue the write-back value it should produce
    task automatic applyStimulus(input logic pcw, input logic jmp, input logic [63:0] target,
                                 input logic [63:0] expWd);
        PCWrite = pcw;
        Jump    = jmp;
        NewPC   = target;
        expQ.push_back(expWd);
        #1;
    endtask

    // Pop the oldest expectation and compare it to the live write-back value
    task automatic checkOutput(input string tag);
        logic [63:0] exp;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard empty observed=%h", tag, writedataa);
        end else begin
            exp = expQ.pop_front();
            check64(tag, writedataa, exp);
        end
    endtask

    // Advance through one rising edge and settle on the following falling edge
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        Reset   = 1'b1;
        PCWrite = 1'b0;
        Jump    = 1'b0;
        NewPC   = 64'd0;
        repeat (2) @(negedge Clk);

        check64("reset_pc",    PCNow, 64'd0);
        check64("reset_instr", {32'd0, Instruction}, 64'h00E08793);
        check64("reset_pc4",   PCNext4, 64'd4);
        Reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 1'b0, 64'd0, wdSeq[i]);
            check64($sformatf("run_pc%0d", i), PCNow, 64'(4 * i));
            check64($sformatf("run_pc4_%0d", i), PCNext4, 64'(4 * i + 4));
            if (i == 9) begin
                check64("beq_rd1",  readdata1, 64'd22);
                check64("beq_rd2",  readdata2, 64'd3);
                check64("beq_zero", {63'd0, zero}, 64'd0);
            end
            checkOutput($sformatf("run_wd%0d", i));
            tick();
        end
        check64("run_end_pc", PCNow, 64'd44);

        applyStimulus(1'b1, 1'b1, 64'h20, 64'd0);
        checkOutput("jump_nop_wd");
        tick();
        check64("jump_pc",    PCNow, 64'h20);
        check64("jump_instr", {32'd0, Instruction}, 64'h005782B3);
        check64("jump_x15",   readdata1, 64'd3);
        check64("jump_x5",    readdata2, 64'd25);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, (k == 1), 64'd0, 64'd28);
            checkOutput($sformatf("hold_wd%0d", k));
            tick();
            check64($sformatf("hold_pc%0d", k), PCNow, 64'h20);
            check64($sformatf("hold_x5_%0d", k), readdata2, 64'd25);
        end

        applyStimulus(1'b1, 1'b1, 64'd0, 64'd28);
        checkOutput("eq_a_wd");
        tick();
        check64("eq_a_pc", PCNow, 64'd0);
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd14);
        checkOutput("eq_b_wd");
        tick();
        applyStimulus(1'b1, 1'b1, 64'h1C, 64'd5);
        checkOutput("eq_c_wd");
        tick();
        check64("eq_c_pc", PCNow, 64'h1C);
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd0);
        checkOutput("eq_d_wd");
        tick();
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd14);
        checkOutput("eq_e_wd");
        tick();
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd0);
        check64("eq_f_pc",   PCNow, 64'h24);
        check64("eq_f_rd1",  readdata1, 64'd14);
        check64("eq_f_rd2",  readdata2, 64'd14);
        check64("eq_f_zero", {63'd0, zero}, 64'd1);
        checkOutput("eq_f_wd");
        tick();
        check64("eq_taken_pc", PCNow, 64'h2C);

        PCWrite = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check64("midrst_pc",    PCNow, 64'd0);
        check64("midrst_instr", {32'd0, Instruction}, 64'h00E08793);
        check64("midrst_pc4",   PCNext4, 64'd4);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check64("post_rst_pc", PCNow, 64'd0);

        applyStimulus(1'b1, 1'b1, 64'h20, 64'd14);
        checkOutput("post_rst_addi_wd");
        tick();
        check64("post_rst_x15", readdata1, 64'd14);
        check64("post_rst_x5",  readdata2, 64'd0);
        applyStimulus(1'b1, 1'b1, 64'h14, 64'd14);
        checkOutput("post_rst_add_wd");
        tick();
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd14);
        check64("x0w_rd2", readdata2, 64'd14);
        checkOutput("x0w_wd");
        tick();
        applyStimulus(1'b1, 1'b1, 64'h14, 64'd14);
        checkOutput("sw_wd");
        tick();
        check64("x0_pc",   PCNow, 64'h14);
        check64("x0_read", readdata1, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
